// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches, pairs in-order responses
// with their fetch PCs and queues them for decode; a redirect flushes and refetches.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        InstrValidD,
    input  logic        InstrReadyD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] qcount_q, qcount_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;
    logic [AW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
    logic [31:0]   pf_mem       [DEPTH];
    logic [31:0]   iq_instr_mem [DEPTH];
    logic [31:0]   iq_pc_mem    [DEPTH];

    logic [CW:0]   occ_s;
    logic [CW-1:0] rsp_dec_s;
    logic          req_valid_s, req_fire_s, rsp_ok_s, redir_s;
    logic          push_s, instr_valid_s, pop_s;

    // Occupancy counts outstanding fetches too, so the queue can never overflow
    assign occ_s         = {1'b0, inflight_q} + {1'b0, qcount_q};
    assign req_valid_s   = (state_q == RUN) && (occ_s < (CW+1)'(DEPTH)) && !redirect_valid;
    assign req_fire_s    = req_valid_s && imem_req_ready;
    assign rsp_ok_s      = imem_rsp_valid && (inflight_q != {CW{1'b0}});
    assign rsp_dec_s     = CW'(rsp_ok_s);
    assign redir_s       = redirect_valid && (state_q != BOOT);
    assign push_s        = rsp_ok_s && (state_q == RUN) && !redirect_valid;
    assign instr_valid_s = (qcount_q != {CW{1'b0}}) && !redirect_valid && (state_q == RUN);
    assign pop_s         = instr_valid_s && InstrReadyD;

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = {pc_q[31:2], 2'b00};
    assign InstrValidD    = instr_valid_s;
    assign InstrD         = (qcount_q != {CW{1'b0}}) ? iq_instr_mem[iq_rd_q] : NOP;
    assign PCD            = (qcount_q != {CW{1'b0}}) ? iq_pc_mem[iq_rd_q] : 32'h0000_0000;
    assign PCPlus4D       = PCD + 32'd4;

    // Next-state logic: FSM, fetch PC, counters and pointers
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(req_fire_s) - rsp_dec_s;
        qcount_d   = qcount_q;
        drop_d     = drop_q;
        pf_wr_d    = pf_wr_q + AW'(req_fire_s);
        pf_rd_d    = pf_rd_q + AW'(rsp_ok_s);
        iq_wr_d    = iq_wr_q;
        iq_rd_d    = iq_rd_q;
        if (redir_s) begin
            // A response landing in the redirect cycle is already stale; count it as dropped
            pc_d     = redirect_pc & ~32'h0000_0003;
            qcount_d = {CW{1'b0}};
            iq_rd_d  = iq_wr_q;
            drop_d   = inflight_q - rsp_dec_s;
            state_d  = (drop_d != {CW{1'b0}}) ? FLUSH : RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    pc_d     = req_fire_s ? (pc_q + 32'd4) : pc_q;
                    qcount_d = qcount_q + CW'(push_s) - CW'(pop_s);
                    iq_wr_d  = iq_wr_q + AW'(push_s);
                    iq_rd_d  = iq_rd_q + AW'(pop_s);
                end
                FLUSH: begin
                    drop_d  = drop_q - rsp_dec_s;
                    state_d = (drop_d == {CW{1'b0}}) ? RUN : FLUSH;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // State, PC, counter and pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= {CW{1'b0}};
            qcount_q   <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
            pf_wr_q    <= {AW{1'b0}};
            pf_rd_q    <= {AW{1'b0}};
            iq_wr_q    <= {AW{1'b0}};
            iq_rd_q    <= {AW{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            qcount_q   <= qcount_d;
            drop_q     <= drop_d;
            pf_wr_q    <= pf_wr_d;
            pf_rd_q    <= pf_rd_d;
            iq_wr_q    <= iq_wr_d;
            iq_rd_q    <= iq_rd_d;
        end
    end

    // Storage for the per-request PC FIFO and the instruction queue; contents need no reset
    always_ff @(posedge clk) begin
        if (req_fire_s) begin
            pf_mem[pf_wr_q] <= imem_req_addr;
        end
        if (push_s) begin
            iq_instr_mem[iq_wr_q] <= imem_rsp_data;
            iq_pc_mem[iq_wr_q]    <= pf_mem[pf_rd_q];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small imem model drives responses, expected decode
// entries go into a scoreboard queue and a forked monitor compares every decode pop.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        InstrValidD, InstrReadyD;
    logic [31:0] InstrD, PCD, PCPlus4D;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .InstrValidD(InstrValidD), .InstrReadyD(InstrReadyD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];   // PCs expected to reach decode, in order
    logic [31:0] out_q[$];   // accepted fetch addresses awaiting a response
    logic [31:0] seen_q[$];  // PCD values popped by decode
    logic [31:0] hs_log[$];  // accepted fetch addresses
    logic [31:0] model_pc;
    int          drop_b;
    int          hs_cnt;
    bit          resp_en;
    bit          stale;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] seen_at(input int i);
        return (seen_q.size() > i) ? seen_q[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] hs_at(input int i);
        return (hs_log.size() > i) ? hs_log[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pops the scoreboard whenever decode takes an entry
    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (InstrValidD && InstrReadyD) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pop: got PCD %h expected no entry", PCD);
                end else begin
                    e = exp_q.pop_front();
                    check("PCD", PCD, e);
                    check("InstrD", InstrD, instr_of(e));
                    check("PCPlus4D", PCPlus4D, e + 32'd4);
                    seen_q.push_back(PCD);
                end
            end
        end
    endtask

    // One clock cycle: sample handshakes mid-cycle, then schedule the next imem response
    task automatic step();
        logic        hs;
        logic        rsp;
        logic [31:0] a;
        logic [31:0] r;
        #2;
        hs  = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        rsp = imem_rsp_valid && !stale;
        if (drop_b > 0 && !redirect_valid) begin
            check("flush_req_valid", 32'(imem_req_valid), 32'd0);
            check("flush_instr_valid", 32'(InstrValidD), 32'd0);
        end
        if (rsp) begin
            r = out_q.pop_front();
            if (!redirect_valid) begin
                if (drop_b > 0) drop_b--;
                else exp_q.push_back(r);
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            drop_b   = out_q.size();
            model_pc = redirect_pc & ~32'd3;
        end
        if (hs) begin
            check("req_addr", a, model_pc);
            model_pc = model_pc + 32'd4;
            out_q.push_back(a);
            hs_log.push_back(a);
            hs_cnt++;
        end
        @(posedge clk);
        #1;
        stale = 1'b0;
        if (resp_en && out_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(out_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0000_0000;
        end
    endtask

    initial begin
        int sidx;
        int hidx;
        reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        InstrReadyD = 1'b0;
        model_pc = RST_PC; drop_b = 0; hs_cnt = 0; resp_en = 1'b1; stale = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        @(posedge clk); #2;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(InstrValidD), 32'd0);
        check("rst_InstrD", InstrD, 32'h0000_0013);
        check("rst_PCD", PCD, 32'h0000_0000);
        check("rst_PCPlus4D", PCPlus4D, 32'h0000_0004);
        check("rst_req_addr", imem_req_addr, 32'hFFFF_FFF8);

        // Back-to-back streaming across the address wrap
        @(posedge clk); #1;
        reset = 1'b1; imem_req_ready = 1'b1; InstrReadyD = 1'b1;
        #1 check("boot_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (10) step();
        check("stream_addr0", hs_at(0), 32'hFFFF_FFF8);
        check("stream_addr1", hs_at(1), 32'hFFFF_FFFC);
        check("stream_addr2", hs_at(2), 32'h0000_0000);
        check("stream_addr3", hs_at(3), 32'h0000_0004);
        check("stream_addr4", hs_at(4), 32'h0000_0008);
        check("stream_pcd0", seen_at(0), 32'hFFFF_FFF8);
        check("stream_pcd2", seen_at(2), 32'h0000_0000);
        check("stream_pcd4", seen_at(4), 32'h0000_0008);
        imem_req_ready = 1'b0;
        repeat (4) step();

        // Decode stalled: exactly four fetches, then drain in order
        seen_q.delete(); hs_log.delete(); hs_cnt = 0;
        InstrReadyD = 1'b0; imem_req_ready = 1'b1;
        repeat (10) step();
        #1;
        check("stall_hs_cnt", 32'(hs_cnt), 32'd4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_instr_valid", 32'(InstrValidD), 32'd1);
        InstrReadyD = 1'b1; imem_req_ready = 1'b0;
        repeat (6) step();
        check("drain_count", 32'(seen_q.size()), 32'd4);
        check("drain_first", seen_at(0), hs_at(0));
        check("drain_last", seen_at(3), hs_at(3));

        // Redirect to 0x100 with two queued and two in flight
        seen_q.delete(); hs_log.delete(); hs_cnt = 0;
        InstrReadyD = 1'b0; imem_req_ready = 1'b1; resp_en = 1'b1;
        for (int i = 0; i < 20 && hs_cnt < 2; i++) step();
        imem_req_ready = 1'b0;
        repeat (3) step();
        resp_en = 1'b0; imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && hs_cnt < 4; i++) step();
        imem_req_ready = 1'b0;
        check("pre_redirect_inflight", 32'(out_q.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        #1;
        check("redirect_instr_valid", 32'(InstrValidD), 32'd0);
        check("redirect_req_valid", 32'(imem_req_valid), 32'd0);
        hs_log.delete(); seen_q.delete();
        resp_en = 1'b1; imem_req_ready = 1'b1; InstrReadyD = 1'b1;
        repeat (8) step();
        check("redirect_addr", hs_at(0), 32'h0000_0100);
        check("redirect_pcd", seen_at(0), 32'h0000_0100);
        check("redirect_pcd_next", seen_at(1), 32'h0000_0104);

        // Misaligned redirect target while streaming, response arriving the same cycle
        hidx = hs_log.size();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        sidx = seen_q.size();
        repeat (6) step();
        check("align_addr", hs_at(hidx), 32'h0000_0200);
        check("align_pcd", seen_at(sidx), 32'h0000_0200);

        // Reset with three queued and one in flight
        imem_req_ready = 1'b0;
        repeat (4) step();
        hs_cnt = 0; InstrReadyD = 1'b0; imem_req_ready = 1'b1; resp_en = 1'b1;
        for (int i = 0; i < 20 && hs_cnt < 3; i++) step();
        resp_en = 1'b0;
        for (int i = 0; i < 20 && hs_cnt < 4; i++) step();
        repeat (2) step();
        #1;
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_instr_valid", 32'(InstrValidD), 32'd1);
        reset = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        check("mid_rst_instr_valid", 32'(InstrValidD), 32'd0);
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("mid_rst_InstrD", InstrD, 32'h0000_0013);
        check("mid_rst_PCPlus4D", PCPlus4D, 32'h0000_0004);
        out_q.delete(); exp_q.delete(); drop_b = 0; model_pc = RST_PC;
        @(posedge clk); #1;
        reset = 1'b1; stale = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        resp_en = 1'b1; InstrReadyD = 1'b1; imem_req_ready = 1'b1;
        hs_log.delete(); seen_q.delete();
        #1 check("post_rst_boot_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (9) step();
        check("post_rst_addr0", hs_at(0), 32'hFFFF_FFF8);
        check("post_rst_pcd0", seen_at(0), 32'hFFFF_FFF8);
        check("post_rst_pcd2", seen_at(2), 32'h0000_0000);

        imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || out_q.size() > 0); i++) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
